// File: rtl/tx_clkdiv_bank.sv
// Bank of runtime-programmable clock dividers with shadowed glitch-free updates, realign strobe and lock flag.
// Optional macro TX_CLKDIV_RUN_GATE_EN adds run_en to hold every channel until a coherent start.
module tx_clkdiv_bank #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 25,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst,
`ifdef TX_CLKDIV_RUN_GATE_EN
    input  logic              run_en,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_chan,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    input  logic              sync_in,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);
    localparam int unsigned       LOCK_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);
    localparam logic [DIV_W-1:0]  ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0]  TWO      = DIV_W'(2);
    localparam logic [4:0]        NUM_CH_L = 5'(NUM_CH);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] high;
        logic [DIV_W-1:0] phase;
    } ch_cfg_t;

    localparam ch_cfg_t DEF_CFG = '{div:   DIV_W'(DEFAULT_DIV),
                                    high:  DIV_W'(DEFAULT_DIV / 2),
                                    phase: '0};

    typedef enum logic {ST_SETTLE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    ch_cfg_t           act_q [NUM_CH];
    ch_cfg_t           shd_q [NUM_CH];
    ch_cfg_t           eff   [NUM_CH];
    ch_cfg_t           req_cfg;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_d;
    logic              run;
    logic              chan_oob;
    logic              req_bad;
    logic              accept;
    logic              legal_acc;
    lock_state_t       state_q;
    lock_state_t       state_d;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic [LOCK_W-1:0] lock_cnt_d;

`ifdef TX_CLKDIV_RUN_GATE_EN
    assign run = run_en;
`else
    assign run = 1'b1;
`endif

    assign req_cfg = '{div: cfg_div, high: cfg_high, phase: cfg_phase};

    // Request decode; out-of-range channels stay ready so the error can be reported
    always_comb begin
        chan_oob  = ({1'b0, cfg_chan} >= NUM_CH_L);
        cfg_ready = chan_oob;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_chan == 4'(c)) cfg_ready = ~pending_q[c];
        end
        req_bad   = chan_oob || (cfg_div < TWO) || (cfg_high == '0) ||
                    (cfg_high >= cfg_div) || (cfg_phase >= cfg_div);
        accept    = cfg_valid && cfg_ready;
        legal_acc = accept && !req_bad;
    end

    // Per-channel next count; shadows swap in only at a period boundary, realign or while held
    always_comb begin
        wrap   = '0;
        apply  = '0;
        load   = '0;
        clk_d  = '0;
        tick_d = '0;
        eff    = act_q;
        cnt_d  = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            wrap[c]  = (cnt_q[c] == act_q[c].div - ONE);
            apply[c] = pending_q[c] && (wrap[c] || sync_in || !run);
            load[c]  = legal_acc && (cfg_chan == 4'(c));
            if (apply[c]) eff[c] = shd_q[c];
            if (!run)                     cnt_d[c] = eff[c].div - ONE;
            else if (wrap[c] || sync_in)  cnt_d[c] = '0;
            else                          cnt_d[c] = cnt_q[c] + ONE;
            clk_d[c]  = run && (cnt_d[c] < eff[c].high);
            tick_d[c] = run && (cnt_d[c] == eff[c].phase);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= DEF_CFG.div - ONE;
                act_q[c] <= DEF_CFG;
                shd_q[c] <= DEF_CFG;
            end
            pending_q <= '0;
            clk_out   <= '0;
            tick      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                if (apply[c]) act_q[c] <= shd_q[c];
                if (load[c])  shd_q[c] <= req_cfg;
            end
            pending_q <= (pending_q & ~apply) | load;
            clk_out   <= clk_d;
            tick      <= tick_d;
        end
    end

    // Lock FSM: any legal accept restarts settling; counter parks at its top while updates are pending
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (legal_acc) begin
            state_d    = ST_SETTLE;
            lock_cnt_d = '0;
        end else if (state_q == ST_SETTLE) begin
            if (lock_cnt_q == LOCK_MAX) begin
                if (pending_q == '0) state_d = ST_LOCKED;
            end else begin
                lock_cnt_d = lock_cnt_q + LOCK_ONE;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SETTLE;
            lock_cnt_q <= '0;
            locked     <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked     <= (state_d == ST_LOCKED);
            cfg_err    <= accept && req_bad;
        end
    end

endmodule

// File: tb/tb_tx_clkdiv_bank.sv
// Self-checking bench for tx_clkdiv_bank: directed scenarios plus random requests against a period/epoch model.
// Exercises the run_en gate when TX_CLKDIV_RUN_GATE_EN is defined.
module tb_tx_clkdiv_bank;
    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 25;
    localparam int LOCK_CYCLES = 1024;

    logic              refclk    = 1'b0;
    logic              rst       = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [3:0]        cfg_chan  = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic [DIV_W-1:0]  cfg_high  = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              sync_in   = 1'b0;
`ifdef TX_CLKDIV_RUN_GATE_EN
    logic              run_en    = 1'b1;
`endif
    logic              cfg_ready;
    logic              cfg_err;
    logic              locked;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    tx_clkdiv_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .refclk(refclk), .rst(rst),
`ifdef TX_CLKDIV_RUN_GATE_EN
        .run_en(run_en),
`endif
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .sync_in(sync_in),
        .clk_out(clk_out), .tick(tick), .locked(locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: each channel is an epoch t0 (edge index where count was 0) plus period parameters
    int                n, ta;
    int                t0 [NUM_CH];
    int                mdiv [NUM_CH];
    int                mhigh [NUM_CH];
    int                mph [NUM_CH];
    int                sdiv [NUM_CH];
    int                shigh [NUM_CH];
    int                sph [NUM_CH];
    logic [15:0]       mpend;
    logic [NUM_CH-1:0] m_clk, m_tick;
    logic              m_locked, m_err;
    int                vectors = 0;
    int                miscompares = 0;

    function automatic logic m_ready(input logic [3:0] c);
        if (int'(c) >= NUM_CH) return 1'b1;
        return ~mpend[c];
    endfunction

    task automatic model_reset();
        n = 0; ta = 0; mpend = '0; m_locked = 1'b0; m_err = 1'b0; m_clk = '0; m_tick = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            t0[c] = 1; mdiv[c] = DEFAULT_DIV; mhigh[c] = DEFAULT_DIV / 2; mph[c] = 0;
            sdiv[c] = DEFAULT_DIV; shigh[c] = DEFAULT_DIV / 2; sph[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic acc, bad, legal, pany, run_now;
        int   ch, pos;
`ifdef TX_CLKDIV_RUN_GATE_EN
        run_now = run_en;
`else
        run_now = 1'b1;
`endif
        n++;
        ch    = int'(cfg_chan);
        acc   = cfg_valid && m_ready(cfg_chan);
        bad   = (ch >= NUM_CH) || (int'(cfg_div) < 2) || (int'(cfg_high) == 0) ||
                (cfg_high >= cfg_div) || (cfg_phase >= cfg_div);
        legal = acc && !bad;
        pany  = |mpend;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!run_now || sync_in || ((n - t0[c]) % mdiv[c]) == 0) begin
                t0[c] = run_now ? n : n + 1;
                if (mpend[c]) begin
                    mdiv[c] = sdiv[c]; mhigh[c] = shigh[c]; mph[c] = sph[c]; mpend[c] = 1'b0;
                end
            end
        end
        if (legal) begin
            sdiv[ch] = int'(cfg_div); shigh[ch] = int'(cfg_high); sph[ch] = int'(cfg_phase);
            mpend[ch] = 1'b1;
            ta = n; m_locked = 1'b0;
        end else if (!m_locked && (n - ta) >= LOCK_CYCLES && !pany) begin
            m_locked = 1'b1;
        end
        m_err = acc && bad;
        for (int c = 0; c < NUM_CH; c++) begin
            if (run_now) begin
                pos = (n - t0[c]) % mdiv[c];
                m_clk[c]  = (pos < mhigh[c]);
                m_tick[c] = (pos == mph[c]);
            end else begin
                m_clk[c] = 1'b0; m_tick[c] = 1'b0;
            end
        end
    endtask

    always @(posedge refclk or posedge rst) begin
        if (rst) model_reset();
        else     model_edge();
    end

    task automatic set_req(input logic v, input int ch, input int d, input int h, input int p);
        cfg_valid = v; cfg_chan = 4'(ch); cfg_div = 16'(d); cfg_high = 16'(h); cfg_phase = 16'(p);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge refclk); @(negedge refclk);
        vectors++;
        if ({clk_out, tick, locked, cfg_err, cfg_ready} !== {3'b000, 3'b000, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_vals got clk=%b tick=%b lk=%b err=%b rdy=%b", clk_out, tick, locked, cfg_err, cfg_ready);
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge refclk);
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL reset_run n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
            if (n == 1 || n == 13 || n == 26) begin
                vectors++;
                if ((n == 1 && {clk_out, tick} !== 6'b111111) || (n == 13 && clk_out !== 3'b000) ||
                    (n == 26 && tick !== 3'b111)) begin
                    miscompares++;
                    $display("FAIL default_period n=%0d got clk=%b tick=%b", n, clk_out, tick);
                end
            end
        end
    endtask

    task automatic test_lock();
        int guard = 0;
        while (n < 1030 && guard < 2000) begin
            @(negedge refclk);
            guard++;
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL lock_run n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
            if (n == 1023 || n == 1024) begin
                vectors++;
                if (locked !== (n == 1024)) begin
                    miscompares++;
                    $display("FAIL lock_edge n=%0d got locked=%b exp %b", n, locked, (n == 1024));
                end
            end
        end
        vectors++;
        if (guard >= 2000) begin
            miscompares++;
            $display("FAIL lock_timeout n=%0d", n);
        end
    endtask

    task automatic test_program();
        int n_acc, ticks = 0, cyc = 0;
        @(negedge refclk);
        set_req(1'b1, 1, 4, 2, 3);
        n_acc = n + 1;
        #1;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL prog_ready_idle got %b exp 1", cfg_ready);
        end
        @(negedge refclk);
        cfg_valid = 1'b0;
        #1;
        vectors++;
        if ({cfg_ready, locked} !== 2'b00) begin
            miscompares++;
            $display("FAIL prog_pending got rdy=%b locked=%b exp 0 0", cfg_ready, locked);
        end
        repeat (70) begin
            @(negedge refclk);
            vectors++;
            if ({clk_out, tick, locked, cfg_err, cfg_ready} !== {m_clk, m_tick, m_locked, m_err, m_ready(cfg_chan)}) begin
                miscompares++;
                $display("FAIL prog_run n=%0d got %b %b %b %b %b exp %b %b %b %b %b", n, clk_out, tick, locked, cfg_err, cfg_ready, m_clk, m_tick, m_locked, m_err, m_ready(cfg_chan));
            end
            if (!mpend[1] && cyc < 40) begin
                cyc++;
                if (tick[1] === 1'b1) ticks++;
            end
        end
        vectors++;
        if (ticks != 10 || cyc != 40) begin
            miscompares++;
            $display("FAIL prog_ch1_ticks got %0d in %0d cycles exp 10 in 40", ticks, cyc);
        end
    endtask

    task automatic test_illegal();
        int tbl [4][4] = '{'{2, 1, 1, 0}, '{2, 5, 5, 0}, '{2, 8, 1, 8}, '{5, 10, 3, 2}};
        for (int i = 0; i < 4; i++) begin
            @(negedge refclk);
            set_req(1'b1, tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3]);
            @(negedge refclk);
            cfg_valid = 1'b0;
            vectors++;
            if ({cfg_err, clk_out, tick, locked} !== {1'b1, m_clk, m_tick, m_locked}) begin
                miscompares++;
                $display("FAIL illegal_%0d got err=%b clk=%b tick=%b lk=%b exp 1 %b %b %b", i, cfg_err, clk_out, tick, locked, m_clk, m_tick, m_locked);
            end
            @(negedge refclk);
            vectors++;
            if ({cfg_err, clk_out, tick} !== {1'b0, m_clk, m_tick}) begin
                miscompares++;
                $display("FAIL illegal_pulse_%0d got err=%b clk=%b tick=%b", i, cfg_err, clk_out, tick);
            end
        end
    endtask

    task automatic test_sync();
        int guard = 0, n_sync;
        while (m_tick[0] !== 1'b1 && guard < 40) begin
            @(negedge refclk);
            guard++;
        end
        set_req(1'b1, 0, 10, 5, 2);
        @(negedge refclk);
        set_req(1'b1, 2, 6, 3, 1);
        sync_in = 1'b1;
        n_sync = n + 1;
        @(negedge refclk);
        cfg_valid = 1'b0;
        sync_in = 1'b0;
        #1;
        vectors++;
        if ({clk_out, tick, cfg_ready} !== {3'b111, 3'b100, 1'b0}) begin
            miscompares++;
            $display("FAIL sync_align got clk=%b tick=%b rdy2=%b exp 111 100 0", clk_out, tick, cfg_ready);
        end
        repeat (50) begin
            @(negedge refclk);
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL sync_run n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
            if (n == n_sync + 2 || n == n_sync + 5) begin
                vectors++;
                if ((n == n_sync + 2 && tick[0] !== 1'b1) || (n == n_sync + 5 && clk_out[0] !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL sync_ch0_period10 n=%0d got clk=%b tick=%b", n, clk_out, tick);
                end
            end
        end
    endtask

    task automatic test_relock();
        int guard = 0, n_acc;
        while (!m_locked && guard < 1200) begin
            @(negedge refclk);
            guard++;
            vectors++;
            if ({locked, clk_out, tick} !== {m_locked, m_clk, m_tick}) begin
                miscompares++;
                $display("FAIL relock_wait n=%0d got %b %b %b exp %b %b %b", n, locked, clk_out, tick, m_locked, m_clk, m_tick);
            end
        end
        @(negedge refclk);
        vectors++;
        if (locked !== 1'b1 || guard >= 1200) begin
            miscompares++;
            $display("FAIL relock_start got locked=%b exp 1", locked);
        end
        set_req(1'b1, 0, 8, 3, 7);
        n_acc = n + 1;
        guard = 0;
        while (n < n_acc + 1030 && guard < 1200) begin
            @(negedge refclk);
            cfg_valid = 1'b0;
            guard++;
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL relock_run n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
            if (n == n_acc || n == n_acc + 1023 || n == n_acc + 1024) begin
                vectors++;
                if (locked !== (n == n_acc + 1024)) begin
                    miscompares++;
                    $display("FAIL relock_edge n=%0d acc=%0d got locked=%b", n, n_acc, locked);
                end
            end
        end
    endtask

    task automatic test_random();
        int d;
        repeat (1500) begin
            @(negedge refclk);
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL rand_run n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
            d = int'($urandom_range(0, 9));
            set_req($urandom_range(0, 5) == 0, int'($urandom_range(0, 4)), d,
                    int'($urandom_range(0, d)), int'($urandom_range(0, d)));
            sync_in = ($urandom_range(0, 39) == 0);
            #1;
            vectors++;
            if (cfg_ready !== m_ready(cfg_chan)) begin
                miscompares++;
                $display("FAIL rand_ready n=%0d chan=%0d got %b exp %b", n, cfg_chan, cfg_ready, m_ready(cfg_chan));
            end
        end
        @(negedge refclk);
        cfg_valid = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic test_rst_mid();
        int ch = 0;
        for (int c = NUM_CH - 1; c >= 0; c--) if (m_ready(4'(c))) ch = c;
        @(negedge refclk);
        set_req(1'b1, ch, 7, 3, 1);
        @(negedge refclk);
        cfg_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({clk_out, tick, locked, cfg_err, cfg_ready} !== {3'b000, 3'b000, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_async got clk=%b tick=%b lk=%b err=%b rdy=%b", clk_out, tick, locked, cfg_err, cfg_ready);
        end
        @(negedge refclk);
        rst = 1'b0;
        repeat (60) begin
            @(negedge refclk);
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL rst_resume n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
            if (n == 5 || n == 26) begin
                vectors++;
                if ((n == 5 && clk_out !== 3'b111) || (n == 26 && tick !== 3'b111)) begin
                    miscompares++;
                    $display("FAIL rst_no_stale n=%0d got clk=%b tick=%b", n, clk_out, tick);
                end
            end
        end
    endtask

`ifdef TX_CLKDIV_RUN_GATE_EN
    task automatic test_run_gate();
        @(negedge refclk);
        run_en = 1'b0;
        repeat (20) begin
            @(negedge refclk);
            if (n % 7 == 0 && m_ready(4'd1)) set_req(1'b1, 1, 5, 2, 4);
            else cfg_valid = 1'b0;
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {3'b000, 3'b000, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL gate_hold n=%0d got %b %b %b %b", n, clk_out, tick, locked, cfg_err);
            end
        end
        cfg_valid = 1'b0;
        run_en = 1'b1;
        @(negedge refclk);
        vectors++;
        if (clk_out !== 3'b111) begin
            miscompares++;
            $display("FAIL gate_start got clk=%b exp 111", clk_out);
        end
        repeat (40) begin
            @(negedge refclk);
            vectors++;
            if ({clk_out, tick, locked, cfg_err} !== {m_clk, m_tick, m_locked, m_err}) begin
                miscompares++;
                $display("FAIL gate_run n=%0d got %b %b %b %b exp %b %b %b %b", n, clk_out, tick, locked, cfg_err, m_clk, m_tick, m_locked, m_err);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_program();
        test_illegal();
        test_sync();
        test_relock();
        test_random();
        test_rst_mid();
`ifdef TX_CLKDIV_RUN_GATE_EN
        test_run_gate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
